// File: rtl/multi_read_pointer_if.sv
// Read-pointer bundle: writer pointer in, pop request/grant, offered lanes.
// slave = pointer block, master = consumer/writer side.
interface multi_read_pointer_if #(
  parameter int PTR_W = 8,
  parameter int LANES = 4
);
  localparam int CW = $clog2(LANES) + 1;

  logic [PTR_W-1:0]            write_pointer;
  logic                        pop_req;
  logic [CW-1:0]               pop_count;
  logic [LANES-1:0][PTR_W-1:0] O;
  logic [LANES-1:0]            valid_mask;
  logic [PTR_W-1:0]            read_pointer;
  logic [PTR_W-1:0]            occupancy;
  logic                        empty;
  logic [CW-1:0]               pop_grant;
  logic                        overflow_err;
`ifdef MULTI_READ_POINTER_STATS_EN
  logic [15:0]                 pop_total;
`endif

  modport master (
    output write_pointer,
    output pop_req,
    output pop_count,
    input  O,
    input  valid_mask,
    input  read_pointer,
    input  occupancy,
    input  empty,
    input  pop_grant,
    input  overflow_err
`ifdef MULTI_READ_POINTER_STATS_EN
    , input pop_total
`endif
  );

  modport slave (
    input  write_pointer,
    input  pop_req,
    input  pop_count,
    output O,
    output valid_mask,
    output read_pointer,
    output occupancy,
    output empty,
    output pop_grant,
    output overflow_err
`ifdef MULTI_READ_POINTER_STATS_EN
    , output pop_total
`endif
  );
endinterface

// File: rtl/multi_read_pointer.sv
// Multi-lane read pointer: offers LANES addresses, pops up to LANES/cycle.
// Ports: CLK, ASYNCRESETN, bus (slave). MULTI_READ_POINTER_STATS_EN adds pop_total.
module multi_read_pointer #(
  parameter int PTR_W = 8,
  parameter int LANES = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  multi_read_pointer_if.slave  bus
);
  localparam int CW = $clog2(LANES) + 1;
  localparam logic [PTR_W-1:0] HALF =
    {1'b1, {(PTR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    AVAIL = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] rp_nx;
  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] occ_nx;
  logic [CW-1:0]    req_c;
  logic [CW-1:0]    avail;
  logic [CW-1:0]    grant;
  logic             err;

  logic [LANES-1:0][PTR_W-1:0] o;
  logic [LANES-1:0]            vm;

  assign occ = wp_q - rp;
  assign err = (state == ERROR);

  // Compare in 32 bits so narrow pointers
  // never truncate the LANES constant.
  assign req_c =
    (32'(bus.pop_count) > 32'(LANES)) ?
    CW'(LANES) : bus.pop_count;
  assign avail =
    (32'(occ) >= 32'(LANES)) ?
    CW'(LANES) : CW'(occ);

  always_comb begin
    grant = '0;
    if (bus.pop_req && !err)
      grant = (req_c < avail) ? req_c : avail;
  end

  assign rp_nx  = rp + PTR_W'(grant);
  assign occ_nx = bus.write_pointer - rp_nx;

  always_comb begin
    o  = '0;
    vm = '0;
    for (int i = 0; i < LANES; i++) begin
      o[i]  = rp + PTR_W'(i);
      vm[i] = !err && (32'(occ) > 32'(i));
    end
  end

  // Overrun is judged on the occupancy the
  // registers will hold after this edge.
  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY, AVAIL: begin
        if (occ > HALF || occ_nx > HALF)
          state_nx = ERROR;
        else if (occ_nx != '0)
          state_nx = AVAIL;
        else
          state_nx = EMPTY;
      end
      default: state_nx = ERROR;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wp_q  <= '0;
      rp    <= '0;
      state <= EMPTY;
    end else begin
      wp_q  <= bus.write_pointer;
      rp    <= rp_nx;
      state <= state_nx;
    end
  end

  assign bus.O            = o;
  assign bus.valid_mask   = vm;
  assign bus.read_pointer = rp;
  assign bus.occupancy    = occ;
  assign bus.empty        = (occ == '0);
  assign bus.pop_grant    = grant;
  assign bus.overflow_err = err;

`ifdef MULTI_READ_POINTER_STATS_EN
  logic [16:0] pt_sum;
  logic [15:0] pt_q;

  assign pt_sum = {1'b0, pt_q} + 17'(grant);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)
      pt_q <= '0;
    else
      pt_q <= pt_sum[16] ? 16'hFFFF : pt_sum[15:0];
  end

  assign bus.pop_total = pt_q;
`endif

endmodule

// File: tb/tb_multi_read_pointer.sv
// Scoreboard bench for multi_read_pointer (PTR_W=8, LANES=4).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_multi_read_pointer;
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int          cyc;
    string       nm;
    bit          kind;
    logic [7:0]  rp;
    logic [7:0]  occ;
    logic [3:0]  vm;
    logic        e;
    logic        err;
    logic [2:0]  g;
    logic [31:0] o;
    logic [15:0] pt;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  multi_read_pointer_if #(.PTR_W(8), .LANES(4)) bus ();

  multi_read_pointer #(.PTR_W(8), .LANES(4)) dut (
    .CLK(CLK),
    .ASYNCRESETN(rst_n),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void push(
    input string nm,
    input logic [7:0] rp, input logic [7:0] occ,
    input logic [3:0] vm, input logic e,
    input logic err, input logic [2:0] g,
    input logic [31:0] o
  );
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.kind = 1'b0;
    x.rp = rp; x.occ = occ; x.vm = vm;
    x.e = e; x.err = err; x.g = g; x.o = o;
    x.pt = '0;
    sb.push_back(x);
  endfunction

  function automatic void push_rst(input string nm);
    push(nm, 8'h00, 8'h00, 4'b0000, 1'b1,
         1'b0, 3'd0, 32'h03020100);
  endfunction

`ifdef MULTI_READ_POINTER_STATS_EN
  function automatic void push_pt(
    input string nm, input logic [15:0] pt
  );
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.kind = 1'b1;
    x.rp = '0; x.occ = '0; x.vm = '0;
    x.e = 1'b0; x.err = 1'b0; x.g = '0; x.o = '0;
    x.pt = pt;
    sb.push_back(x);
  endfunction
`endif

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      total++;
      if (m.cyc != cyc) begin
        bad++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d",
                 m.nm, cyc, m.cyc);
      end else if (m.kind == 1'b0) begin
        if (bus.read_pointer !== m.rp ||
            bus.occupancy !== m.occ ||
            bus.valid_mask !== m.vm ||
            bus.empty !== m.e ||
            bus.overflow_err !== m.err ||
            bus.pop_grant !== m.g ||
            bus.O !== m.o) begin
          bad++;
          $display({"FAIL %s: got rp=%h occ=%h vm=%b empty=%b ",
                    "err=%b grant=%0d O=%h; want rp=%h occ=%h vm=%b ",
                    "empty=%b err=%b grant=%0d O=%h"},
                   m.nm, bus.read_pointer, bus.occupancy,
                   bus.valid_mask, bus.empty, bus.overflow_err,
                   bus.pop_grant, bus.O, m.rp, m.occ, m.vm,
                   m.e, m.err, m.g, m.o);
        end
      end else begin
`ifdef MULTI_READ_POINTER_STATS_EN
        if (bus.pop_total !== m.pt) begin
          bad++;
          $display("FAIL %s: got pop_total=%h want %h",
                   m.nm, bus.pop_total, m.pt);
        end
`endif
      end
    end
  end

  task automatic drv(
    input logic [7:0] w, input logic r, input logic [2:0] c
  );
    bus.write_pointer = w;
    bus.pop_req = r;
    bus.pop_count = c;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, sb=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drv(8'h00, 1'b1, 3'd4);
    tick();
    push_rst("reset");
    tick();

    rst_n = 1'b1;
    drv(8'h00, 1'b1, 3'd4);
    push_rst("idle_pop");
    tick();
    drv(8'h03, 1'b0, 3'd0);
    push_rst("wp_lag");
    tick();
    drv(8'h03, 1'b0, 3'd0);
    push("occ3", 8'h00, 8'h03, 4'b0111, 1'b0,
         1'b0, 3'd0, 32'h03020100);
    tick();
    drv(8'h03, 1'b1, 3'd4);
    push("pop3", 8'h00, 8'h03, 4'b0111, 1'b0,
         1'b0, 3'd3, 32'h03020100);
    tick();
    drv(8'h03, 1'b0, 3'd0);
    push("after_pop3", 8'h03, 8'h00, 4'b0000, 1'b1,
         1'b0, 3'd0, 32'h06050403);
    tick();

    // walk read_pointer to 8'hFE without overrunning
    repeat (40) begin drv(8'h80, 1'b1, 3'd4); tick(); end
    repeat (40) begin drv(8'hFE, 1'b1, 3'd4); tick(); end

    drv(8'h02, 1'b0, 3'd0);
    push("preload", 8'hFE, 8'h00, 4'b0000, 1'b1,
         1'b0, 3'd0, 32'h0100FFFE);
    tick();
    drv(8'h02, 1'b0, 3'd0);
    push("wrap_occ4", 8'hFE, 8'h04, 4'b1111, 1'b0,
         1'b0, 3'd0, 32'h0100FFFE);
    tick();
    drv(8'h02, 1'b1, 3'd4);
    push("wrap_pop4", 8'hFE, 8'h04, 4'b1111, 1'b0,
         1'b0, 3'd4, 32'h0100FFFE);
    tick();
    drv(8'h02, 1'b0, 3'd0);
    push("wrap_rp", 8'h02, 8'h00, 4'b0000, 1'b1,
         1'b0, 3'd0, 32'h05040302);
    tick();

    rst_n = 1'b0;
    drv(8'h02, 1'b1, 3'd2);
    push_rst("reset_mid_pop");
    tick();
    rst_n = 1'b1;
    drv(8'h02, 1'b0, 3'd0);
    push_rst("post_reset");
    tick();
    drv(8'h06, 1'b1, 3'd2);
    push("simul_pop", 8'h00, 8'h02, 4'b0011, 1'b0,
         1'b0, 3'd2, 32'h03020100);
    tick();
    drv(8'h06, 1'b0, 3'd0);
    push("simul_next", 8'h02, 8'h04, 4'b1111, 1'b0,
         1'b0, 3'd0, 32'h05040302);
    tick();
    drv(8'h06, 1'b1, 3'd7);
    push("clamp", 8'h02, 8'h04, 4'b1111, 1'b0,
         1'b0, 3'd4, 32'h05040302);
    tick();
    drv(8'h06, 1'b0, 3'd0);
    push("clamp_next", 8'h06, 8'h00, 4'b0000, 1'b1,
         1'b0, 3'd0, 32'h09080706);
    tick();

    rst_n = 1'b0;
    drv(8'h00, 1'b0, 3'd0);
    push_rst("reset3");
    tick();
    rst_n = 1'b1;
    drv(8'h80, 1'b0, 3'd0);
    tick();
    drv(8'h80, 1'b0, 3'd0);
    push("full_ok", 8'h00, 8'h80, 4'b1111, 1'b0,
         1'b0, 3'd0, 32'h03020100);
    tick();
    drv(8'h81, 1'b0, 3'd0);
    push("full_hold", 8'h00, 8'h80, 4'b1111, 1'b0,
         1'b0, 3'd0, 32'h03020100);
    tick();
    drv(8'h81, 1'b1, 3'd4);
    push("overflow", 8'h00, 8'h81, 4'b0000, 1'b0,
         1'b1, 3'd0, 32'h03020100);
    tick();
    drv(8'h81, 1'b1, 3'd4);
    push("err_hold", 8'h00, 8'h81, 4'b0000, 1'b0,
         1'b1, 3'd0, 32'h03020100);
    tick();
    drv(8'h00, 1'b0, 3'd0);
    push("err_wp0", 8'h00, 8'h81, 4'b0000, 1'b0,
         1'b1, 3'd0, 32'h03020100);
    tick();
    drv(8'h00, 1'b1, 3'd4);
    push("err_sticky", 8'h00, 8'h00, 4'b0000, 1'b1,
         1'b1, 3'd0, 32'h03020100);
    tick();
    rst_n = 1'b0;
    drv(8'h00, 1'b0, 3'd0);
    push_rst("reset_clear");
    tick();
    rst_n = 1'b1;
    push_rst("after_release");
    tick();

`ifdef MULTI_READ_POINTER_STATS_EN
    begin
      logic [7:0] w;
      w = 8'h00;
      repeat (20000) begin
        w = w + 8'd4;
        drv(w, 1'b1, 3'd4);
        tick();
      end
      w = w + 8'd4;
      drv(w, 1'b1, 3'd4);
      push_pt("pt_sat", 16'hFFFF);
      tick();
      rst_n = 1'b0;
      push_pt("pt_reset", 16'h0000);
      tick();
      rst_n = 1'b1;
      drv(8'h00, 1'b0, 3'd0);
      tick();
    end
`endif

    tick();
    tick();
    while (sb.size() > 0) begin
      m = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked, required cycle %0d",
               m.nm, m.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_read_pointer.md
MULTI_READ_POINTER -- requirements
Module: multi_read_pointer

Interface
REQ-001 Parameter PTR_W, default 8, pointer width: the MSB is the wrap bit and the lower PTR_W-1 bits are the address; the legal range is 2..16.
REQ-002 Parameter LANES, default 4, number of read addresses offered per cycle; the legal range is 1..8.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 ASYNCRESETN  input  1  asynchronous active-low reset.
REQ-005 write_pointer  input  PTR_W  writer-side pointer (wrap bit plus address).
REQ-006 pop_req  input  1  consumer requests a pop this cycle.
REQ-007 pop_count  input  clog2(LANES)+1  number of entries requested; 0..LANES.
REQ-008 O  output  LANES x PTR_W  offered read pointers, O[i] = read_pointer + i mod 2^PTR_W.
REQ-009 valid_mask  output  LANES  valid_mask[i] = 1 iff O[i] addresses an occupied entry.
REQ-010 read_pointer  output  PTR_W  current registered read pointer.
REQ-011 occupancy  output  PTR_W  entry count = wp_q - read_pointer mod 2^PTR_W.
REQ-012 empty  output  1  high iff occupancy == 0.
REQ-013 pop_grant  output  clog2(LANES)+1  number of entries actually consumed this cycle.
REQ-014 overflow_err  output  1  sticky error flag.

Function
REQ-015 write_pointer SHALL be registered into wp_q, so a writer update becomes visible in occupancy one cycle later.
REQ-016 occupancy, empty, O, valid_mask and pop_grant SHALL be combinational from wp_q, read_pointer and the current inputs.
REQ-017 valid_mask[i] SHALL be 1 iff i < min(occupancy, LANES).
REQ-018 pop_grant SHALL be min(pop_count, occupancy, LANES) when pop_req=1, otherwise 0; a pop_count above LANES SHALL be clamped to LANES.
REQ-019 read_pointer SHALL advance by pop_grant on each rising edge, using modulo-2^PTR_W arithmetic that carries into the wrap bit.
REQ-020 O[i] SHALL wrap modulo 2^PTR_W, for example read_pointer 8'hFE gives O = {8'h01, 8'h00, 8'hFF, 8'hFE} for lanes 3..0.
REQ-021 The FSM SHALL have three states, EMPTY, AVAIL and ERROR, and reset to EMPTY.
REQ-022 EMPTY->AVAIL when the next occupancy is nonzero; AVAIL->EMPTY when the next occupancy is zero.
REQ-023 Any state SHALL go to ERROR when occupancy > 2^(PTR_W-1), which indicates writer overrun.
REQ-024 ERROR SHALL be exited only by reset.
REQ-025 In ERROR: overflow_err=1, pop_grant=0, valid_mask=0, and read_pointer holds.
REQ-026 A simultaneous write_pointer change and pop SHALL both take effect: occupancy in the next cycle = new wp_q - (read_pointer + pop_grant).
REQ-027 A pop with occupancy 0 SHALL grant 0 and is not an error.
REQ-028 occupancy == 2^(PTR_W-1) (full) SHALL be legal and SHALL NOT cause ERROR.

Reset
REQ-029 Asserting ASYNCRESETN low SHALL immediately clear, without waiting for a clock edge: wp_q=0, read_pointer=0, state=EMPTY, overflow_err=0.
REQ-030 During reset: O[i]=i, valid_mask=0, occupancy=0, empty=1, pop_grant=0.
REQ-031 Reset asserted mid-pop SHALL discard the pop; the first grant after release is computed from the zeroed state.
REQ-032 Reset release SHALL be synchronous to CLK at the user level; the first state update occurs on the first rising edge with ASYNCRESETN=1.

Configuration
REQ-033 With macro MULTI_READ_POINTER_STATS_EN defined, the block SHALL add output pop_total (16 bits).
REQ-034 pop_total SHALL accumulate pop_grant each cycle, saturating at 16'hFFFF, and reset to 0.
REQ-035 Without MULTI_READ_POINTER_STATS_EN, the pop_total port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then hold write_pointer=8'h00 -> empty=1, valid_mask=4'b0000, O={3,2,1,0}, and pop_req=1 with pop_count=4 gives pop_grant=0.
REQ-037 write_pointer=8'h03 -> one cycle later occupancy=3 and valid_mask=4'b0111; pop_count=4 -> pop_grant=3, next read_pointer=8'h03, then empty=1.
REQ-038 Preload read_pointer to 8'hFE (write_pointer=8'hFE, pop to match), then write_pointer=8'h02 -> occupancy=4, O={01,00,FF,FE}, and pop of 4 gives read_pointer=8'h02.
REQ-039 With read_pointer=0, write_pointer=8'h80 -> occupancy=128, no error; write_pointer=8'h81 -> one cycle later overflow_err=1 and pops are ignored, and it clears only after ASYNCRESETN pulses low.
REQ-040 Same cycle: write_pointer goes 8'h02->8'h06 while pop_count=2 with occupancy=2 -> next cycle occupancy=4 and read_pointer=8'h02.
REQ-041 With MULTI_READ_POINTER_STATS_EN defined, 20000 grants of 4 -> pop_total saturates at 16'hFFFF; asserting reset mid-run -> pop_total=0 immediately.
